// File: rtl/onehot_dec_pkg.sv
// Shared types, default widths and the one-hot decode helper for onehot_dec_seq.
package onehot_dec_pkg;

  localparam int SEL_W  = 3;
  localparam int OUT_W  = 8;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] to_onehot(input logic [SEL_W-1:0] code);
    logic [OUT_W-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec_seq_hold_cnt.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module hold_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_dec_seq.sv
// Sequential 3:8 one-hot decoder: drives 1<<code for hold+1 cycles, then a one-cycle gap.
// Define ONEHOT_DEC_B2B_EN to accept the next code on the last drive cycle and skip the gap.
module onehot_dec_seq #(
  parameter int SEL_W  = onehot_dec_pkg::SEL_W,
  parameter int OUT_W  = onehot_dec_pkg::OUT_W,
  parameter int HOLD_W = onehot_dec_pkg::HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_code,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [OUT_W-1:0]  y,
  output logic              out_valid,
  output logic              done,
  output logic              busy
);

  import onehot_dec_pkg::*;

  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic              cnt_zero;
  logic              take;

`ifdef ONEHOT_DEC_B2B_EN
  assign in_ready = (state == IDLE) || ((state == DRIVE) && cnt_zero);
`else
  assign in_ready = (state == IDLE);
`endif

  assign take = in_valid && in_ready;

  hold_cnt #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (take),
    .dec      (state == DRIVE),
    .load_val (in_hold),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // done is registered, so it is raised one edge early: when the counter is about to reach zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state     <= DRIVE;
            y         <= to_onehot(in_code);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= (in_hold == '0);
          end
        end
        DRIVE: begin
          if (take) begin
            y         <= to_onehot(in_code);
            out_valid <= 1'b1;
            done      <= (in_hold == '0);
          end else if (cnt_zero) begin
            state     <= GAP;
            y         <= '0;
            out_valid <= 1'b0;
          end else begin
            done <= (cnt == HOLD_W'(1));
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          y         <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
